// File: rtl/rng_sched_pkg.sv
// Shared types and constants for the RNG burst scheduler: FSM encoding,
// default field widths and a constant-safe ceil(log2) helper.
package rng_sched_pkg;

    typedef enum logic [1:0] {
        StWarm  = 2'd0,
        StIdle  = 2'd1,
        StBurst = 2'd2
    } state_e;

    localparam int unsigned DefLenW   = 8;
    localparam int unsigned DefWarmup = 4;

    // Never returns less than 1 so a single-entry index still has a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/rng_burst_scheduler_rr_pick.sv
// Combinational round-robin selector: searches upward from the entry after
// the last winner and returns the first requester found, one-hot and indexed.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PtrW = rng_sched_pkg::clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PtrW-1:0] last_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [PtrW-1:0] idx_o
);

    logic            found;
    logic [PtrW-1:0] pos;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        pos      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            pos = PtrW'((32'(last_i) + k) % NREQ);
            if (!found && req_i[pos]) begin
                found         = 1'b1;
                onehot_o[pos] = 1'b1;
                idx_o         = pos;
            end
        end
    end

endmodule

// File: rtl/rng_burst_scheduler.sv
// Arbitrates one shared LFSR word stream among NREQ burst requesters, with a
// warm-up hold-off after reset while the generator reseeds.
module rng_burst_scheduler
    import rng_sched_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned W      = 16,
    parameter int unsigned LEN_W  = DefLenW,
    parameter int unsigned WARMUP = DefWarmup
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          rnd_in,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       grant,
    output logic [W-1:0]          rnd_out,
    output logic                  rnd_valid,
    output logic [NREQ-1:0]       done,
    output logic                  busy
);

    localparam int unsigned PtrW  = clog2(NREQ);
    localparam int unsigned WarmW = clog2(WARMUP + 1);

    state_e           state_q;
    logic [WarmW-1:0] warm_q;
    logic [LEN_W-1:0] len_q;
    logic [PtrW-1:0]  ptr_q;

    logic [NREQ-1:0]  win_onehot;
    logic [PtrW-1:0]  win_idx;
    logic [LEN_W-1:0] win_len;
    logic [LEN_W-1:0] lens [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_len
        assign lens[i] = req_len[i*LEN_W +: LEN_W];
    end

    rr_pick #(
        .NREQ (NREQ),
        .PtrW (PtrW)
    ) u_rr_pick (
        .req_i    (req),
        .last_i   (ptr_q),
        .onehot_o (win_onehot),
        .idx_o    (win_idx)
    );

    assign win_len = lens[win_idx];
    assign busy    = (state_q != StIdle);

    // len_q counts the words still owed after the one currently presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StWarm;
            warm_q    <= WarmW'(WARMUP);
            len_q     <= '0;
            ptr_q     <= PtrW'(NREQ - 1);
            grant     <= '0;
            rnd_out   <= '0;
            rnd_valid <= 1'b0;
            done      <= '0;
        end else begin
            unique case (state_q)
                StWarm: begin
                    warm_q <= warm_q - WarmW'(1);
                    if (warm_q <= WarmW'(1)) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (|req) begin
                        state_q   <= StBurst;
                        grant     <= win_onehot;
                        ptr_q     <= win_idx;
                        rnd_out   <= rnd_in;
                        rnd_valid <= (win_len != '0);
                        done      <= (win_len <= LEN_W'(1)) ? win_onehot : '0;
                        len_q     <= (win_len == '0) ? '0 : win_len - LEN_W'(1);
                    end
                end
                StBurst: begin
                    if (len_q == '0) begin
                        state_q   <= StIdle;
                        grant     <= '0;
                        rnd_valid <= 1'b0;
                        done      <= '0;
                    end else begin
                        rnd_out   <= rnd_in;
                        rnd_valid <= 1'b1;
                        len_q     <= len_q - LEN_W'(1);
                        done      <= (len_q == LEN_W'(1)) ? grant : '0;
                    end
                end
                default: state_q <= StWarm;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_burst_scheduler.sv
// Scoreboard bench for rng_burst_scheduler: directed bursts push expected
// output beats, a negedge monitor pops and compares every presented beat.
module tb_rng_burst_scheduler;

    localparam int NREQ   = 4;
    localparam int W      = 16;
    localparam int LEN_W  = 8;
    localparam int WARMUP = 4;

    logic                  clk;
    logic                  rst;
    logic [W-1:0]          rnd_in;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       grant;
    logic [W-1:0]          rnd_out;
    logic                  rnd_valid;
    logic [NREQ-1:0]       done;
    logic                  busy;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] grant;
        logic            valid;
        logic [W-1:0]    word;
        logic [NREQ-1:0] done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   seen [logic [W-1:0]];
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   t0;

    rng_burst_scheduler #(
        .NREQ   (NREQ),
        .W      (W),
        .LEN_W  (LEN_W),
        .WARMUP (WARMUP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rnd_in    (rnd_in),
        .req       (req),
        .req_len   (req_len),
        .grant     (grant),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid),
        .done      (done),
        .busy      (busy)
    );

    function automatic logic [W-1:0] word_at(int c);
        return 16'h8000 + 16'(c);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Request granted in IDLE cycle t: beat k appears at t+1+k carrying rnd_in(t+k).
    task automatic expect_burst(int t, int idx, int len, int npush);
        int n;
        n = (len == 0) ? 1 : len;
        for (int k = 0; k < npush && k < n; k++) begin
            exp_t e;
            e.cyc   = t + 1 + k;
            e.grant = NREQ'(1) << idx;
            e.valid = (len != 0);
            e.word  = word_at(t + k);
            e.done  = (k == n - 1) ? (NREQ'(1) << idx) : '0;
            exp_q.push_back(e);
        end
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after the burst.
    task automatic serve(int idx, int len);
        int n;
        n = (len == 0) ? 1 : len;
        req[idx] = 1'b1;
        req_len[idx*LEN_W +: LEN_W] = LEN_W'(len);
        expect_burst(cyc, idx, len, n);
        repeat (n) step();
        req[idx] = 1'b0;
        step();
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc    = 0;
        rnd_in = word_at(0);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            rnd_in = word_at(cyc);
        end
    end

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL missing_beat: got nothing at cycle %0d, expected grant=%b word=%h done=%b",
                     exp_q[0].cyc, exp_q[0].grant, exp_q[0].word, exp_q[0].done);
            void'(exp_q.pop_front());
        end
        if (rnd_valid === 1'b1 || |done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got grant=%b valid=%b word=%h done=%b, expected none",
                         grant, rnd_valid, rnd_out, done);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_cycle", cyc, mon_e.cyc);
                check("beat_grant", 32'(grant), 32'(mon_e.grant));
                check("beat_valid", 32'(rnd_valid), 32'(mon_e.valid));
                check("beat_done", 32'(done), 32'(mon_e.done));
                if (mon_e.valid) begin
                    check("beat_word", 32'(rnd_out), 32'(mon_e.word));
                    check("word_unique", 32'(seen.exists(rnd_out)), 0);
                    seen[rnd_out] = 1'b1;
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        req      = '0;
        req_len  = '0;
        step();
        step();
        check("rst_grant", 32'(grant), 0);
        check("rst_valid", 32'(rnd_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 1);

        // Requester 0 asks immediately; nothing may be granted during warm-up.
        rst = 1'b0;
        req = 4'b0001;
        req_len[0 +: LEN_W] = 8'd3;
        for (int i = 0; i < WARMUP; i++) begin
            check("warm_busy", 32'(busy), 1);
            check("warm_grant", 32'(grant), 0);
            step();
        end
        check("idle_busy", 32'(busy), 0);
        serve(0, 3);

        // All four at len 2; last winner was 0 so the order is 1,2,3,0.
        req     = 4'b1111;
        req_len = {4{8'd2}};
        serve(1, 2);
        serve(2, 2);
        serve(3, 2);
        serve(0, 2);
        check("idle_after_rr", 32'(busy), 0);

        // Make 3 the last winner, then 1010 must give 1 then 3.
        req_len = {4{8'd1}};
        serve(3, 1);
        req = 4'b1010;
        serve(1, 1);
        serve(3, 1);

        // Pointer at 1, then 1101 with len[2]=0: 2 (empty burst), 3, 0.
        serve(1, 1);
        req     = 4'b1101;
        req_len = {8'd1, 8'd0, 8'd1, 8'd1};
        serve(2, 0);
        serve(3, 1);
        serve(0, 1);

        // Requester 1 drops req mid-burst; all 4 words must still arrive.
        t0  = cyc;
        req = 4'b0010;
        req_len[1*LEN_W +: LEN_W] = 8'd4;
        expect_burst(t0, 1, 4, 4);
        step();
        step();
        req = '0;
        step();
        step();
        step();
        check("drop_busy", 32'(busy), 0);

        // Reset during the second word of a len-5 burst from requester 2.
        t0  = cyc;
        req = 4'b0100;
        req_len[2*LEN_W +: LEN_W] = 8'd5;
        expect_burst(t0, 2, 5, 2);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = '0;
        check("abort_grant", 32'(grant), 0);
        check("abort_valid", 32'(rnd_valid), 0);
        check("abort_done", 32'(done), 0);
        check("abort_busy", 32'(busy), 1);
        for (int i = 1; i < WARMUP; i++) begin
            step();
            check("rewarm_busy", 32'(busy), 1);
        end
        step();
        check("rewarm_idle", 32'(busy), 0);

        // Stale pointer (last winner 2) would favour 3; reset must favour 0.
        req     = 4'b1001;
        req_len = {4{8'd1}};
        serve(0, 1);
        serve(3, 1);

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
